// File: rtl/dot_prod_feeder.sv
// Streams aligned reference/received sample pairs into the CAF dot-product correlator,
// one window per lag, with the received window sliding by one sample per lag.
module dot_prod_feeder #(
    parameter int xi_bits             = 12,
    parameter int xq_bits             = 12,
    parameter int yi_bits             = 12,
    parameter int yq_bits             = 12,
    parameter int length              = 5,
    parameter int length_counter_bits = 3,
    parameter int num_lags            = 3,
    parameter int lag_bits            = 2,
    parameter int rx_addr_bits        = 3,
    parameter bit conj_y              = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ref_we,
    input  logic [length_counter_bits-1:0] ref_addr,
    input  logic [xi_bits-1:0]             ref_i,
    input  logic [xq_bits-1:0]             ref_q,
    input  logic                           rx_we,
    input  logic [rx_addr_bits-1:0]        rx_addr,
    input  logic [yi_bits-1:0]             rx_i,
    input  logic [yq_bits-1:0]             rx_q,
    input  logic                           start,
    input  logic                           m_axis_tready,
    output logic                           s_axis_x_tvalid,
    output logic                           s_axis_y_tvalid,
    output logic [xi_bits-1:0]             xi,
    output logic [xq_bits-1:0]             xq,
    output logic [yi_bits-1:0]             yi,
    output logic [yq_bits-1:0]             yq,
    output logic [lag_bits-1:0]            lag,
    output logic                           busy,
    output logic                           done
);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_DONE} state_t;

    state_t r_state, w_state_next;

    logic [xi_bits+xq_bits-1:0] r_ref_mem [0:(1<<length_counter_bits)-1];
    logic [yi_bits+yq_bits-1:0] r_rx_mem  [0:(1<<rx_addr_bits)-1];
    logic [xi_bits+xq_bits-1:0] r_ref_rd;
    logic [yi_bits+yq_bits-1:0] r_rx_rd;

    logic [length_counter_bits-1:0] r_k;
    logic [lag_bits-1:0]            r_l;
    logic                           r_issue_done;
    logic                           r_q_valid;
    logic                           r_q_last;
    logic [lag_bits-1:0]            r_q_lag;

    logic                r_valid;
    logic                r_last;
    logic [lag_bits-1:0] r_lag;
    logic [xi_bits-1:0]  r_xi;
    logic [xq_bits-1:0]  r_xq;
    logic [yi_bits-1:0]  r_yi;
    logic [yq_bits-1:0]  r_yq;

    logic                    w_idle;
    logic                    w_k_last;
    logic                    w_l_last;
    logic                    w_xfer;
    logic                    w_load;
    logic                    w_rd;
    logic [rx_addr_bits-1:0] w_rx_rd_addr;
    logic [yq_bits-1:0]      w_rx_q;
    logic [yq_bits-1:0]      w_q_min;
    logic [yq_bits-1:0]      w_yq;

    assign w_idle       = (r_state == S_IDLE);
    assign w_k_last     = (r_k == length_counter_bits'(length - 1));
    assign w_l_last     = (r_l == lag_bits'(num_lags - 1));
    assign w_xfer       = r_valid & m_axis_tready;
    // The RAM read register acts as the skid stage: it is only refilled when the
    // output register takes its pair, so a stall freezes both stages.
    assign w_load       = r_q_valid & (~r_valid | m_axis_tready);
    assign w_rd         = (r_state == S_PRIME) |
                          ((r_state == S_STREAM) & ~r_issue_done & (~r_q_valid | w_load));
    assign w_rx_rd_addr = rx_addr_bits'(r_k) + rx_addr_bits'(r_l);

    assign w_rx_q  = r_rx_rd[yq_bits-1:0];
    assign w_q_min = {1'b1, {(yq_bits-1){1'b0}}};
    // Negating the most-negative code would overflow, so it saturates to max positive.
    assign w_yq    = !conj_y ? w_rx_q :
                     (w_rx_q == w_q_min) ? ~w_q_min : (~w_rx_q + 1'b1);

    always_ff @(posedge clk) begin
        if (ref_we && w_idle) begin
            r_ref_mem[ref_addr] <= {ref_i, ref_q};
        end
        if (w_rd) begin
            r_ref_rd <= r_ref_mem[r_k];
        end
    end

    always_ff @(posedge clk) begin
        if (rx_we && w_idle) begin
            r_rx_mem[rx_addr] <= {rx_i, rx_q};
        end
        if (w_rd) begin
            r_rx_rd <= r_rx_mem[w_rx_rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_PRIME;
            S_PRIME:  w_state_next = S_STREAM;
            S_STREAM: if (w_xfer && r_last) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k          <= '0;
            r_l          <= '0;
            r_issue_done <= 1'b0;
            r_q_valid    <= 1'b0;
            r_q_last     <= 1'b0;
            r_q_lag      <= '0;
        end else if (w_idle) begin
            r_k          <= '0;
            r_l          <= '0;
            r_issue_done <= 1'b0;
            r_q_valid    <= 1'b0;
        end else if (w_rd) begin
            r_q_valid <= 1'b1;
            r_q_last  <= w_k_last & w_l_last;
            r_q_lag   <= r_l;
            if (w_k_last) begin
                r_k <= '0;
                if (w_l_last) begin
                    r_issue_done <= 1'b1;
                end else begin
                    r_l <= r_l + 1'b1;
                end
            end else begin
                r_k <= r_k + 1'b1;
            end
        end else if (w_load) begin
            r_q_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_lag   <= '0;
            r_xi    <= '0;
            r_xq    <= '0;
            r_yi    <= '0;
            r_yq    <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_last  <= r_q_last;
            r_lag   <= r_q_lag;
            r_xi    <= r_ref_rd[xi_bits+xq_bits-1 -: xi_bits];
            r_xq    <= r_ref_rd[xq_bits-1:0];
            r_yi    <= r_rx_rd[yi_bits+yq_bits-1 -: yi_bits];
            r_yq    <= w_yq;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    assign s_axis_x_tvalid = r_valid;
    assign s_axis_y_tvalid = r_valid;
    assign xi              = r_xi;
    assign xq              = r_xq;
    assign yi              = r_yi;
    assign yq              = r_yq;
    assign lag             = r_lag;
    assign busy            = (r_state == S_PRIME) | (r_state == S_STREAM);
    assign done            = (r_state == S_DONE);

endmodule
